seg_display_arbiter: RTL



---
 rtl/seg_display_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// Shares the left/right 4-digit seven-segment banks between three frame
// producers with fixed priority, a minimum hold time and tear-free refresh.
module seg_display_arbiter #(
  parameter int SCAN_DIV = 200000,
  parameter int MIN_HOLD = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  input  logic        blank,
  output logic [2:0]  grant,
  output logic [7:0]  seg_l,
  output logic [7:0]  seg_r,
  output logic [3:0]  an_l,
  output logic [3:0]  an_r
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHOW   = 2'd1;
  localparam logic [1:0] LINGER = 2'd2;

  logic [CNT_W-1:0]  scan_cnt;
  logic [1:0]        idx;
  logic [1:0]        state, state_n;
  logic [2:0]        grant_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [63:0]       latch, latch_n;

  logic        tick;
  logic        owner_req;
  logic [2:0]  above;
  logic [2:0]  top_grant;
  logic [63:0] frame_top, frame_own;
  logic        new_grant;

  assign tick      = (scan_cnt == CNT_MAX);
  assign owner_req = |(req & grant);

  always_comb begin
    above = 3'b000;
    case (grant)
      3'b001:  above = 3'b110;
      3'b010:  above = 3'b100;
      default: above = 3'b000;
    endcase
  end

  always_comb begin
    top_grant = 3'b000;
    if (req[2])      top_grant = 3'b100;
    else if (req[1]) top_grant = 3'b010;
    else if (req[0]) top_grant = 3'b001;
  end

  always_comb begin
    frame_top = frame0;
    case (top_grant)
      3'b100:  frame_top = frame2;
      3'b010:  frame_top = frame1;
      default: frame_top = frame0;
    endcase
  end

  always_comb begin
    frame_own = frame0;
    case (grant)
      3'b100:  frame_own = frame2;
      3'b010:  frame_own = frame1;
      default: frame_own = frame0;
    endcase
  end

  // A new grant always wins over the per-state defaults computed above it.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    latch_n   = latch;
    new_grant = 1'b0;
    if (state != IDLE && tick && hold != HOLD_MAX)
      hold_n = hold + HOLD_W'(1);
    else
      hold_n = hold;

    case (state)
      IDLE: begin
        if (|req) new_grant = 1'b1;
      end
      SHOW: begin
        if (|(req & above))  new_grant = 1'b1;
        else if (!owner_req) state_n = LINGER;
        else if (tick)       latch_n = frame_own;
      end
      LINGER: begin
        if (|(req & above)) new_grant = 1'b1;
        else if (owner_req) state_n = SHOW;
        else if (hold == HOLD_MAX) begin
          if (|req) new_grant = 1'b1;
          else begin
            state_n = IDLE;
            grant_n = 3'b000;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 3'b000;
      end
    endcase

    if (new_grant) begin
      state_n = SHOW;
      grant_n = top_grant;
      latch_n = frame_top;
      hold_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      state    <= IDLE;
      grant    <= 3'b000;
      hold     <= '0;
      latch    <= 64'd0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CNT_W'(1);
      if (tick) idx <= idx + 2'd1;
      state <= state_n;
      grant <= grant_n;
      hold  <= hold_n;
      latch <= latch_n;
    end
  end

  // Pins follow the registered state, so they trail a new grant by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_l  <= 4'b0000;
      an_r  <= 4'b0000;
      seg_l <= 8'h00;
      seg_r <= 8'h00;
    end else if (state == IDLE || blank) begin
      an_l  <= 4'b0000;
      an_r  <= 4'b0000;
      seg_l <= 8'h00;
      seg_r <= 8'h00;
    end else begin
      an_l  <= 4'b0001 << idx;
      an_r  <= 4'b0001 << idx;
      seg_l <= latch[{3'b000, idx} * 5'd8 +: 8];
      seg_r <= latch[6'd32 + {4'b0000, idx} * 6'd8 +: 8];
    end
  end

endmodule
